// File: rtl/cam_pkg.sv
// cam_pkg: capture FSM states, RGB565-to-RGB332 field positions and default frame geometry
package cam_pkg;

   typedef enum logic [2:0] {WAIT_FRAME, IDLE_LINE, BYTE1, BYTE2, END_FRAME} cam_state_t;

   localparam int IMG_W_DEF = 160;
   localparam int IMG_H_DEF = 120;
   localparam int AW_DEF    = 17;

   // byte1 = {R[4:0], G[5:3]}, byte2 = {G[2:0], B[4:0]}: keep the top bits of each colour
   localparam int R_MSB  = 7;
   localparam int G_MSB  = 2;
   localparam int B_MSB  = 4;

   function automatic logic [7:0] rgb332(input logic [7:0] b1, input logic [7:0] b2);
      return {b1[R_MSB -: 3], b1[G_MSB -: 3], b2[B_MSB -: 2]};
   endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: registers vsync/href once and flags vsync edges on the registered copy
module cam_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   input  logic href,
   output logic vs_rise,
   output logic vs_fall,
   output logic href_q
);

   logic vs_q, vs_d;

   always_ff @(posedge clk) begin
      if (reset) {vs_q, vs_d, href_q} <= '0;
      else {vs_q, vs_d, href_q} <= {vsync, vs_q, href};
   end

   assign vs_rise = vs_q & ~vs_d;
   assign vs_fall = ~vs_q & vs_d;

endmodule

// File: rtl/cam_capture_rgb332.sv
// cam_capture_rgb332: OV7670 RGB565 stream to RGB332 frame-buffer writes; CAM_TESTPAT_EN adds a colour-bar test pattern
module cam_capture_rgb332
   import cam_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = 8,
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
`ifdef CAM_TESTPAT_EN
   input  logic          testpat,
`endif
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    px_data,
   output logic [AW-1:0] mem_px_addr,
   output logic [DW-1:0] mem_px_data,
   output logic          px_wr,
   output logic          frame_done,
   output logic          frame_err
);

   localparam int NPIX = IMG_W * IMG_H;
   localparam int CW   = $clog2(IMG_W + 1);
   localparam int RW   = $clog2(IMG_H + 1);
   localparam int PW   = $clog2(NPIX + 2);

   cam_state_t    state;
   logic          vs_rise, vs_fall, href_q;
   logic [7:0]    data_q, byte1, pixel;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [PW-1:0] pix_cnt;
   logic [AW-1:0] addr, line_base;
   logic          in_bounds;

   cam_sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .vsync  (vsync),
      .href   (href),
      .vs_rise(vs_rise),
      .vs_fall(vs_fall),
      .href_q (href_q)
   );

   always_ff @(posedge clk) begin
      if (reset) data_q <= '0;
      else data_q <= px_data;
   end

   assign in_bounds = (col < CW'(IMG_W)) && (row < RW'(IMG_H));

`ifdef CAM_TESTPAT_EN
   logic       tp;
   logic [2:0] bar;
   assign bar   = 3'((32'(col) * 8) / IMG_W);
   assign pixel = tp ? {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}} : rgb332(byte1, data_q);
`else
   assign pixel = rgb332(byte1, data_q);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= WAIT_FRAME;
         row         <= '0;
         col         <= '0;
         pix_cnt     <= '0;
         addr        <= '0;
         line_base   <= '0;
         byte1       <= '0;
         mem_px_addr <= '0;
         mem_px_data <= '0;
         px_wr       <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
`ifdef CAM_TESTPAT_EN
         tp          <= 1'b0;
`endif
      end else begin
         px_wr      <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            WAIT_FRAME: if (vs_fall && enable) begin
               state     <= IDLE_LINE;
               row       <= '0;
               line_base <= '0;
               pix_cnt   <= '0;
               frame_err <= 1'b0;
`ifdef CAM_TESTPAT_EN
               tp        <= testpat;
`endif
            end
            IDLE_LINE: begin
               if (vs_rise) state <= END_FRAME;
               else if (href_q) begin
                  byte1 <= data_q;
                  col   <= '0;
                  addr  <= line_base;
                  state <= BYTE2;
               end
            end
            BYTE1, BYTE2: begin
               // href low also ends the line in BYTE2, discarding an odd trailing byte
               if (vs_rise) state <= END_FRAME;
               else if (!href_q) begin
                  row       <= (&row) ? row : row + 1'b1;
                  line_base <= line_base + AW'(IMG_W);
                  state     <= IDLE_LINE;
               end else if (state == BYTE1) begin
                  byte1 <= data_q;
                  state <= BYTE2;
               end else begin
                  if (in_bounds) begin
                     px_wr       <= 1'b1;
                     mem_px_addr <= addr;
                     mem_px_data <= DW'(pixel);
                  end else frame_err <= 1'b1;
                  pix_cnt <= (&pix_cnt) ? pix_cnt : pix_cnt + 1'b1;
                  col     <= (&col) ? col : col + 1'b1;
                  addr    <= addr + 1'b1;
                  state   <= BYTE1;
               end
            end
            END_FRAME: begin
               frame_done <= 1'b1;
               frame_err  <= frame_err | (pix_cnt != PW'(NPIX));
               state      <= WAIT_FRAME;
            end
            default: state <= WAIT_FRAME;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// tb_cam_capture_rgb332: randomized camera frames scored against a pixel-level model of expected buffer writes
module tb_cam_capture_rgb332;

   localparam int W = 16, H = 12, N = W * H, AW = 8;

   typedef struct {
      int     addr;
      int     data;
      longint cyc;
   } wr_t;

   logic          clk = 0, reset = 1, enable = 0, vsync = 1, href = 0;
   logic [7:0]    px_data = 0;
   logic [AW-1:0] mem_px_addr;
   logic [7:0]    mem_px_data;
   logic          px_wr, frame_done, frame_err;
`ifdef CAM_TESTPAT_EN
   logic          testpat = 0;
`endif

   int     checks = 0, errors = 0, fd_cnt = 0;
   longint cyc = 0;
   bit     mon_on = 0, exp_wr, exp_err = 0, tp = 0;
   wr_t    q[$];

   cam_capture_rgb332 #(.AW(AW), .DW(8), .IMG_W(W), .IMG_H(H)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
`ifdef CAM_TESTPAT_EN
      .testpat    (testpat),
`endif
      .vsync      (vsync),
      .href       (href),
      .px_data    (px_data),
      .mem_px_addr(mem_px_addr),
      .mem_px_data(mem_px_data),
      .px_wr      (px_wr),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // RGB565 colour components truncated to 3/3/2 bits
   function automatic int conv(input int b1, input int b2);
      int p = b1 * 256 + b2;
      return ((p >> 11) >> 2) * 32 + (((p >> 5) & 63) >> 3) * 4 + ((p & 31) >> 3);
   endfunction

   function automatic int bar_color(input int c);
      int b = c * 8 / W;
      return ((b >> 2) & 1) * 'hE0 + ((b >> 1) & 1) * 'h1C + (b & 1) * 'h03;
   endfunction

   always @(negedge clk) begin
      if (mon_on) begin
         if (frame_done) fd_cnt++;
         exp_wr = q.size() > 0 && q[0].cyc == cyc;
         checks++;
         assert (px_wr === exp_wr) else begin
            errors++;
            $error("FAIL px_wr cyc %0d got %b exp %b", cyc, px_wr, exp_wr);
         end
         if (exp_wr) begin
            checks += 2;
            assert (mem_px_addr === AW'(q[0].addr)) else begin
               errors++;
               $error("FAIL addr cyc %0d got %0d exp %0d", cyc, mem_px_addr, q[0].addr);
            end
            assert (mem_px_data === 8'(q[0].data)) else begin
               errors++;
               $error("FAIL data addr %0d got %h exp %h", q[0].addr, mem_px_data, q[0].data);
            end
            void'(q.pop_front());
         end
         checks++;
         assert (int'(mem_px_addr) < N) else begin
            errors++;
            $error("FAIL addr_range got %0d exp <%0d", mem_px_addr, N);
         end
      end
   end

   task automatic put(input bit vs, input bit hr, input logic [7:0] d);
      @(posedge clk);
      #1;
      vsync   = vs;
      href    = hr;
      px_data = d;
   endtask

   // nl lines; line sl has spx pixels (+odd byte); reset before pixel rst_at; mode picks byte pairs
   task automatic frame(input bit en, input int nl, input int sl, input int spx, input bit odd,
                        input int rst_at, input int mode, input bit stuck);
      bit cap = en, drop = 0;
      int tot = 0, fd0 = fd_cnt, np, b1, b2;
      enable = en;
`ifdef CAM_TESTPAT_EN
      testpat = tp;
`endif
      repeat (4) put(1, 0, 0);
      repeat (4) put(0, 0, 0);
      enable = !en;
      @(negedge clk);
      checks++;
      assert (frame_err === (cap ? 1'b0 : exp_err)) else begin
         errors++;
         $error("FAIL err_clear got %b exp %b", frame_err, cap ? 1'b0 : exp_err);
      end
      for (int r = 0; r < nl; r++) begin
         np = (r == sl) ? spx : W;
         for (int c = 0; c < np; c++) begin
            if (tot == rst_at) begin
               reset = 1;
               while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
               cap = 0;
               exp_err = 0;
               @(posedge clk);
               @(negedge clk);
               checks++;
               assert ({px_wr, frame_done, frame_err, mem_px_addr, mem_px_data} === '0) else begin
                  errors++;
                  $error("FAIL reset_out got %b%b%b %0d %h exp 0", px_wr, frame_done, frame_err,
                         mem_px_addr, mem_px_data);
               end
               @(posedge clk);
               #1 reset = 0;
            end
            b1 = mode == 1 ? 'hF8 : mode == 2 ? 'h07 : mode == 3 ? 'h00 : int'($urandom_range(255));
            b2 = mode == 1 ? 'h00 : mode == 2 ? 'hFF : mode == 3 ? 'h18 : int'($urandom_range(255));
            put(0, 1, 8'(b1));
            put(0, 1, 8'(b2));
            if (cap && r < H && c < W) q.push_back('{r * W + c, tp ? bar_color(c) : conv(b1, b2), cyc + 2});
            else if (cap) drop = 1;
            tot++;
         end
         if (r == sl && odd) put(0, 1, 8'($urandom_range(255)));
         if (!(stuck && r == nl - 1)) repeat ($urandom_range(2, 5)) put(0, 0, 0);
      end
      if (stuck) begin
         put(0, 1, 8'($urandom_range(255)));
         put(1, 1, 8'($urandom_range(255)));
         put(1, 1, 8'($urandom_range(255)));
      end
      repeat (8) put(1, 0, 0);
      if (cap) exp_err = (tot != N) || drop;
      @(negedge clk);
      checks += 3;
      assert (fd_cnt - fd0 === int'(cap)) else begin
         errors++;
         $error("FAIL frame_done got %0d exp %0d", fd_cnt - fd0, int'(cap));
      end
      assert (frame_err === exp_err) else begin
         errors++;
         $error("FAIL frame_err got %b exp %b", frame_err, exp_err);
      end
      assert (q.size() === 0) else begin
         errors++;
         $error("FAIL missing_writes got %0d exp 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      assert ({px_wr, frame_done, frame_err, mem_px_addr, mem_px_data} === '0) else begin
         errors++;
         $error("FAIL reset_state got %b%b%b %0d %h exp 0", px_wr, frame_done, frame_err,
                mem_px_addr, mem_px_data);
      end
      mon_on = 1;
      @(posedge clk);
      #1 reset = 0;
      frame(1, H,     -1, 0,     0, -1,  1, 0);
      frame(1, H,     -1, 0,     0, -1,  2, 1);
      frame(1, H,     -1, 0,     0, -1,  3, 0);
      frame(1, H + 1,  5, W + 1, 0, -1,  0, 0);
      frame(1, H,      3, 10,    1, -1,  0, 0);
      frame(1, H,     -1, 0,     0, 100, 0, 0);
      frame(0, H,     -1, 0,     0, -1,  0, 0);
      frame(1, H,     -1, 0,     0, -1,  0, 0);
`ifdef CAM_TESTPAT_EN
      tp = 1;
      frame(1, H,     -1, 0,     0, -1,  0, 0);
      tp = 0;
      frame(1, H,     -1, 0,     0, -1,  0, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
